// File: rtl/rv32_x_pkg.sv
// Shared types for the rv32i_x instruction prefetch path.
// Holds the prefetch FSM encoding, the FIFO entry layout and the
// word-alignment helper used on redirect targets.
package rv32_x_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    // Prefetch control states: one idle cycle after reset, then run.
    typedef enum logic {
        PFB_WAIT = 1'b0,
        PFB_RUN  = 1'b1
    } pfb_state_e;

    // One buffered instruction: the fetched word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } pfb_entry_t;

    // Clear the byte-offset bits so an address points at a whole instruction.
    function automatic logic [XLEN-1:0] pfb_word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/pfb_fifo.sv
// Synchronous FIFO for the instruction prefetch buffer.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// flush has priority over push/pop and empties the queue in one cycle.
module pfb_fifo
    import rv32_x_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  pfb_entry_t    push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output pfb_entry_t    head_entry
);

    pfb_entry_t    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    // Write the incoming entry at the tail slot.
    // NOTE: the storage array is deliberately left without a reset; count gates
    // every read, so no slot is observed before it has been written, and
    // leaving it out keeps the array a plain RAM without per-bit reset logic.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= push_entry;
        end
    end

    // Track head, tail and occupancy; a flush empties the queue outright.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours and the
    // result does not depend on the order the simulator evaluates blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head_entry = mem[head];

endmodule

// File: rtl/iccm_prefetch_buffer.sv
// Instruction prefetch queue between the rv32i_x fetch stage and the ICCM.
// Issues sequential word reads ahead of the core, buffers the returned words
// with their PCs, and hands them to the core over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the new target.
//
// Optional build macro PFB_PERF_CNT_EN adds two saturating counters:
//   perf_issue_cnt - ICCM reads issued
//   perf_drop_cnt  - in-flight returns discarded plus entries flushed by redirect
module iccm_prefetch_buffer
    import rv32_x_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            iccm_rd_en,
    output logic [XLEN-1:0] iccm_rd_addr,
    input  logic [XLEN-1:0] iccm_rd_data
`ifdef PFB_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issue_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

    pfb_state_e      state;
    logic [XLEN-1:0] fetch_pc;
    logic            pend;
    logic [XLEN-1:0] pend_pc;

    logic [CW-1:0]   fifo_count;
    pfb_entry_t      head_entry;
    pfb_entry_t      push_entry;
    pfb_entry_t      last_entry;

    logic            handshake;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    // ------------------------------------------------------------------
    // Handshake, return and credit decisions
    // ------------------------------------------------------------------
    assign inst_valid = (fifo_count != '0);
    assign handshake  = inst_valid && inst_ready;

    // A redirect discards the head and the word returning this cycle. The
    // read that was in flight when the redirect arrived returns in that very
    // cycle (one-cycle ICCM), so suppressing the push here is what drops it;
    // the first read to the new target is then pushed normally two cycles on.
    assign pop  = handshake && !redirect_valid;
    assign push = pend && !redirect_valid;

    // Entries the queue will hold once this cycle's pop and return settle.
    // The pending return is counted as a credit even before it lands, which
    // is what keeps the FIFO from ever overflowing.
    assign occupancy = {1'b0, fifo_count}
                     + {{CW{1'b0}}, pend}
                     - {{CW{1'b0}}, handshake};

    assign issue = (state == PFB_RUN) && !redirect_valid && (occupancy < DEPTH_OCC);

    assign iccm_rd_en   = issue;
    assign iccm_rd_addr = fetch_pc;

    assign push_entry = '{data: iccm_rd_data, pc: pend_pc};

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    pfb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head_entry (head_entry)
    );

    // ------------------------------------------------------------------
    // Control FSM, fetch PC and outstanding-read tracking
    // ------------------------------------------------------------------
    // Step the FSM, advance the fetch PC on each issue, and note whether a
    // read is outstanding so its data is pushed on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PFB_WAIT;
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            pend_pc  <= '0;
        end else begin
            case (state)
                PFB_WAIT: state <= PFB_RUN;
                PFB_RUN:  state <= PFB_RUN;
                default:  state <= PFB_WAIT;
            endcase

            if (redirect_valid) begin
                // Last redirect wins; no read issues in a redirect cycle.
                fetch_pc <= pfb_word_align(redirect_pc);
                pend     <= 1'b0;
            end else begin
                pend <= issue;
                if (issue) begin
                    pend_pc  <= fetch_pc;
                    // Natural 32-bit overflow wraps 0xFFFF_FFFC back to 0.
                    fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Core-facing outputs
    // ------------------------------------------------------------------
    // Remember the head so inst_data/inst_pc hold their last value once empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_entry <= '0;
        end else if (inst_valid) begin
            last_entry <= head_entry;
        end
    end

    assign inst_data = inst_valid ? head_entry.data : last_entry.data;
    assign inst_pc   = inst_valid ? head_entry.pc   : last_entry.pc;

`ifdef PFB_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, perf_drop_cnt} + 33'(fifo_count) + 33'(pend);

    // Count issued reads and discarded work, both saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (issue && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_iccm_prefetch_buffer.sv
// Self-checking bench for iccm_prefetch_buffer.
// A queue-based reference model predicts every output each cycle from the
// handshake rules; directed scenarios pin key timings with literal values,
// then a randomized phase mixes stalls and redirects.
module tb_iccm_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        iccm_rd_en;
    logic [31:0] iccm_rd_addr;
    logic [31:0] iccm_rd_data;
`ifdef PFB_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    iccm_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .iccm_rd_en     (iccm_rd_en),
        .iccm_rd_addr   (iccm_rd_addr),
        .iccm_rd_data   (iccm_rd_data)
`ifdef PFB_PERF_CNT_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] iccm_word(input logic [31:0] a);
        return 32'h00A0_0000 | a;
    endfunction

    // ICCM model: data for a read strobed in one cycle appears the next cycle.
    logic        rsp_en   = 1'b0;
    logic [31:0] rsp_addr = '0;
    always @(negedge clk) begin
        rsp_en   = iccm_rd_en;
        rsp_addr = iccm_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        iccm_rd_data = rsp_en ? iccm_word(rsp_addr) : 32'hDEAD_BEEF;
    end

    // Reference model state and observation logs.
    logic [31:0] m_q[$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fetch;
    logic        m_wait;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_data;
    int          m_issue;
    int          m_drop;

    int          cyc = 0;
    int          first_en_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] issued[$];
    logic [31:0] delivered[$];
    int          delivered_cyc[$];

    // Compare process: predict this cycle's outputs, check them, then advance.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_pop;
        logic exp_en;
        int   occ;
        if (rst) begin
            m_q.delete();
            m_pend      = 1'b0;
            m_pend_pc   = '0;
            m_fetch     = 32'h0;
            m_wait      = 1'b1;
            m_last_pc   = '0;
            m_last_data = '0;
            m_issue     = 0;
            m_drop      = 0;
            cyc             = 0;
            first_en_cyc    = -1;
            first_valid_cyc = -1;
            issued.delete();
            delivered.delete();
            delivered_cyc.delete();
            check("rst_inst_valid", 64'(inst_valid), 64'd0);
            check("rst_iccm_rd_en", 64'(iccm_rd_en), 64'd0);
            check("rst_inst_pc", 64'(inst_pc), 64'd0);
            check("rst_inst_data", 64'(inst_data), 64'd0);
            check("rst_iccm_rd_addr", 64'(iccm_rd_addr), 64'd0);
        end else begin
            cyc++;
            exp_valid = (m_q.size() != 0);
            if (exp_valid) begin
                m_last_pc   = m_q[0];
                m_last_data = iccm_word(m_q[0]);
            end
            exp_pop = exp_valid && inst_ready;
            occ     = m_q.size() - int'(exp_pop) + int'(m_pend);
            exp_en  = !m_wait && !redirect_valid && (occ < DEPTH);

            check("m_inst_valid", 64'(inst_valid), 64'(exp_valid));
            check("m_inst_pc", 64'(inst_pc), 64'(m_last_pc));
            check("m_inst_data", 64'(inst_data), 64'(m_last_data));
            check("m_iccm_rd_en", 64'(iccm_rd_en), 64'(exp_en));
            check("m_iccm_rd_addr", 64'(iccm_rd_addr), 64'(m_fetch));
`ifdef PFB_PERF_CNT_EN
            check("m_perf_issue", 64'(perf_issue_cnt), 64'(m_issue));
            check("m_perf_drop", 64'(perf_drop_cnt), 64'(m_drop));
`endif

            if (iccm_rd_en) begin
                issued.push_back(iccm_rd_addr);
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (inst_valid && inst_ready && !redirect_valid) begin
                delivered.push_back(inst_pc);
                delivered_cyc.push_back(cyc);
            end

            if (exp_en) m_issue++;
            if (redirect_valid) begin
                m_drop += m_q.size() + int'(m_pend);
                m_q.delete();
                m_fetch = redirect_pc & 32'hFFFF_FFFC;
                m_pend  = 1'b0;
            end else begin
                if (exp_pop) void'(m_q.pop_front());
                if (m_pend) m_q.push_back(m_pend_pc);
                if (exp_en) begin
                    m_pend_pc = m_fetch;
                    m_fetch   = m_fetch + 32'd4;
                end
                m_pend = exp_en;
            end
            m_wait = 1'b0;
        end
    end

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 400 && cyc < n; k++) peek();
        check("wait_cyc_reached", 64'(cyc), 64'(n));
    endtask

    // Assert reset just after an edge, confirm outputs clear at once, release.
    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #2;
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("async_rst_valid", 64'(inst_valid), 64'd0);
        check("async_rst_rd_en", 64'(iccm_rd_en), 64'd0);
        check("async_rst_pc", 64'(inst_pc), 64'd0);
        check("async_rst_data", 64'(inst_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        inst_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found8;
        logic [31:0] r;
        logic [31:0] rpc;
        logic rdy;
        logic rv;
        int base;

        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iccm_rd_data   = '0;

        // 1: start-up latency and sequential streaming.
        do_reset(1'b1);
        wait_cyc(12);
        check("t1_first_rd_en_cyc", 64'(first_en_cyc), 64'd2);
        check("t1_first_valid_cyc", 64'(first_valid_cyc), 64'd4);
        check("t1_ndelivered_ge4", 64'(delivered.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < delivered.size()) begin
                check("t1_pc_seq", 64'(delivered[i]), 64'(32'(i * 4)));
                check("t1_pc_cycle", 64'(delivered_cyc[i]), 64'(4 + i));
            end
        end

        // 2: credit limit with the core stalled, then pop and issue together.
        do_reset(1'b0);
        wait_cyc(10);
        check("t2_reads_issued", 64'(issued.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < issued.size()) check("t2_issue_addr", 64'(issued[i]), 64'(32'(i * 4)));
        end
        check("t2_full_no_issue", 64'(iccm_rd_en), 64'd0);
        step(1'b1, 1'b0, '0);
        peek();
        check("t2_head_pc", 64'(inst_pc), 64'h0);
        check("t2_head_data", 64'(inst_data), 64'h00A0_0000);
        check("t2_pop_issue_en", 64'(iccm_rd_en), 64'd1);
        check("t2_pop_issue_addr", 64'(iccm_rd_addr), 64'h10);

        // 5: asynchronous reset mid-stream with a read outstanding.
        do_reset(1'b0);
        wait_cyc(5);
        check("t5_valid_before_rst", 64'(inst_valid), 64'd1);
        do_reset(1'b1);
        wait_cyc(8);
        check("t5_restart_rd_en_cyc", 64'(first_en_cyc), 64'd2);
        check("t5_restart_valid_cyc", 64'(first_valid_cyc), 64'd4);
        if (delivered.size() > 0) check("t5_first_pc", 64'(delivered[0]), 64'h0);
        else check("t5_delivered_any", 64'd0, 64'd1);

        // 3: redirect while the read to 0x8 is in flight.
        do_reset(1'b1);
        wait_cyc(4);
        step(1'b1, 1'b1, 32'h0000_0103);
        peek();
        check("t3_redir_cycle_pc", 64'(inst_pc), 64'h4);
        check("t3_redir_no_issue", 64'(iccm_rd_en), 64'd0);
        step(1'b1, 1'b0, '0);
        peek();
        check("t3_new_rd_en", 64'(iccm_rd_en), 64'd1);
        check("t3_new_rd_addr", 64'(iccm_rd_addr), 64'h100);
        check("t3_empty_t1", 64'(inst_valid), 64'd0);
`ifdef PFB_PERF_CNT_EN
        check("t6_perf_drop", 64'(perf_drop_cnt), 64'd2);
        check("t6_perf_issue", 64'(perf_issue_cnt), 64'd3);
`endif
        peek();
        check("t3_empty_t2", 64'(inst_valid), 64'd0);
        peek();
        check("t3_valid_t3", 64'(inst_valid), 64'd1);
        check("t3_pc_t3", 64'(inst_pc), 64'h100);
        check("t3_data_t3", 64'(inst_data), 64'h00A0_0100);
        wait_cyc(14);
        found8 = 1'b0;
        foreach (delivered[i]) if (delivered[i] == 32'h8) found8 = 1'b1;
        check("t3_no_stale_0x8", 64'(found8), 64'd0);
        if (delivered.size() >= 2) check("t3_after_redirect", 64'(delivered[1]), 64'h100);
        else check("t3_ndelivered", 64'(delivered.size()), 64'd2);

        // 4: redirect near the top of the address space, fetch wraps to 0.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        peek();
        issued.delete();
        delivered.delete();
        delivered_cyc.delete();
        step(1'b1, 1'b0, '0);
        base = cyc;
        wait_cyc(base + 10);
        begin
            logic [31:0] exp_seq [4];
            exp_seq[0] = 32'hFFFF_FFF8;
            exp_seq[1] = 32'hFFFF_FFFC;
            exp_seq[2] = 32'h0000_0000;
            exp_seq[3] = 32'h0000_0004;
            check("t4_nissued_ge4", 64'(issued.size() >= 4), 64'd1);
            check("t4_ndelivered_ge4", 64'(delivered.size() >= 4), 64'd1);
            for (int i = 0; i < 4; i++) begin
                if (i < issued.size()) check("t4_issue_wrap", 64'(issued[i]), 64'(exp_seq[i]));
                if (i < delivered.size()) check("t4_deliver_wrap", 64'(delivered[i]), 64'(exp_seq[i]));
            end
        end

        // Randomized phase: stalls, bursts of back-pressure and redirects.
        for (int k = 0; k < 800; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ((k % 100) < 8) rdy = 1'b0;
            rv = ($urandom_range(0, 19) == 0);
            if ((k % 150) == 60) rv = 1'b1;
            r = $urandom();
            rpc = r[0] ? (32'hFFFF_FFF0 | (r & 32'h0000_000F)) : r;
            step(rdy, rv, rpc);
        end
        step(1'b1, 1'b0, '0);
        repeat (10) @(posedge clk);
        peek();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
